// File: rtl/ecdsa_axis_pkg.sv
// ecdsa_axis_pkg: shared signature-packet widths and output FSM states for the ECDSA AXI-stream path
package ecdsa_axis_pkg;
  localparam int BEAT_W_DEF = 256;
  localparam int BEATS_DEF = 2;
  localparam int PKT_W_DEF = BEAT_W_DEF * BEATS_DEF;
  typedef enum logic {IDLE, SEND} pkt_state_t;
endpackage

// File: rtl/sig_pkt_buf.sv
// sig_pkt_buf: 2-entry ping-pong packet store with push/pop/full/empty
module sig_pkt_buf
  import ecdsa_axis_pkg::*;
#(
  parameter int W = PKT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   count;
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count <= count + 2'(push) - 2'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/axis_sig_packetizer.sv
// axis_sig_packetizer: splits buffered signature packets into AXI-stream beats, low slice first (SIG_BSWAP_EN byte-reverses each beat)
module axis_sig_packetizer
  import ecdsa_axis_pkg::*;
#(
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int BEATS = BEATS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BEAT_W*BEATS-1:0] sig_data,
  input  logic                    sig_valid,
  output logic                    sig_ready,
  output logic [BEAT_W-1:0]       outa_tdata,
  output logic                    outa_tvalid,
  input  logic                    outa_tready,
  output logic                    outa_tlast,
  output logic                    busy,
  output logic [15:0]             pkt_count
);
  localparam int PW = BEAT_W * BEATS;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  pkt_state_t        state;
  logic [CW-1:0]     beat;
  logic              live, push, pop, full, empty, send, last, hs;
  logic [PW-1:0]     head;
  logic [BEAT_W-1:0] slice, beat_out;
  assign send = state == SEND;
  assign last = beat == CW'(BEATS - 1);
  assign hs = send && outa_tready;
  assign pop = hs && last;
  assign push = sig_valid && sig_ready;
  assign sig_ready = live && !full;
  assign outa_tvalid = send;
  assign outa_tlast = send && last;
  assign busy = !empty || send;
  assign slice = head[beat*BEAT_W +: BEAT_W];
  assign outa_tdata = send ? beat_out : '0;
`ifdef SIG_BSWAP_EN
  for (genvar k = 0; k < BEAT_W / 8; k++) begin : g_swap
    assign beat_out[8*k +: 8] = slice[BEAT_W-8*k-8 +: 8];
  end
`else
  assign beat_out = slice;
`endif
  sig_pkt_buf #(.W(PW)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (sig_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  // a same-cycle accept keeps the buffer non-empty, so SEND rolls into the next packet without a bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      live <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      live <= 1'b1;
      if (!send) begin
        if (!empty) begin
          state <= SEND;
          beat <= '0;
        end
      end else if (hs) begin
        beat <= last ? '0 : beat + CW'(1);
        if (last) begin
          pkt_count <= pkt_count + 16'd1;
          if (!(full || push)) state <= IDLE;
        end
      end
    end
endmodule

// File: tb/tb_axis_sig_packetizer.sv
// tb_axis_sig_packetizer: directed stimulus checked against a beat-queue model plus pinned literal expectations
module tb_axis_sig_packetizer;
  import ecdsa_axis_pkg::*;
  localparam int BW = 256;
  localparam int NB = 2;
  logic clk = 1'b0, rst = 1'b1, sig_valid = 1'b0, outa_tready = 1'b0;
  logic [BW*NB-1:0] sig_data = '0;
  logic sig_ready, outa_tvalid, outa_tlast, busy;
  logic [BW-1:0] outa_tdata;
  logic [15:0] pkt_count;
  int checks = 0, errors = 0;
  typedef struct packed { logic [BW-1:0] d; logic l; } beat_t;
  beat_t q[$];
  int pend = 0;
  bit m_send = 0, m_up = 0;
  logic [15:0] m_cnt = 16'd0;
  axis_sig_packetizer #(.BEAT_W(BW), .BEATS(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_data    (sig_data),
    .sig_valid   (sig_valid),
    .sig_ready   (sig_ready),
    .outa_tdata  (outa_tdata),
    .outa_tvalid (outa_tvalid),
    .outa_tready (outa_tready),
    .outa_tlast  (outa_tlast),
    .busy        (busy),
    .pkt_count   (pkt_count)
  );
  always #5 clk = ~clk;
  function automatic logic [BW-1:0] xf(input logic [BW-1:0] s);
`ifdef SIG_BSWAP_EN
    return {<<8{s}};
`else
    return s;
`endif
  endfunction
  task automatic chk(input string n, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // model: a packet occupies the block from acceptance until its last beat handshakes
  always @(negedge clk) begin : mon
    int pb;
    bit acc, hs, lh;
    if (rst) begin
      q.delete();
      pend = 0;
      m_send = 0;
      m_up = 0;
      m_cnt = 16'd0;
      chk("rst_tdata", outa_tdata, '0);
      chk("rst_tlast", outa_tlast, 0);
    end
    chk("m_ready", sig_ready, m_up && pend < 2);
    chk("m_tvalid", outa_tvalid, m_send);
    chk("m_busy", busy, pend != 0 || m_send);
    chk("m_pkt_count", pkt_count, m_cnt);
    if (m_send) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_queue got=empty want=beat");
      end else begin
        chk("m_tdata", outa_tdata, q[0].d);
        chk("m_tlast", outa_tlast, q[0].l);
      end
    end
    if (!rst) begin
      pb = pend;
      acc = sig_valid && m_up && pend < 2;
      hs = m_send && outa_tready && q.size() > 0;
      lh = hs && q[0].l;
      if (hs) void'(q.pop_front());
      if (lh) begin
        pend--;
        m_cnt++;
      end
      if (acc) begin
        for (int b = 0; b < NB; b++) q.push_back('{d: xf(sig_data[b*BW +: BW]), l: b == NB - 1});
        pend++;
      end
      m_send = m_send ? !(lh && pend == 0) : pb > 0;
      m_up = 1;
    end
  end
  initial begin
    logic [BW-1:0] seq [6];
    logic [BW-1:0] ta, tb, p1a, p1b, p2a, p2b, p3a, p3b, s0, s0x;
    bit acc;
    ta = {16{16'hAAAA}};
    tb = {16{16'hBBBB}};
    repeat (2) tick;
    chk("reset_ready", sig_ready, 0);
    chk("reset_tvalid", outa_tvalid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pkt_count", pkt_count, 0);
    rst = 1'b0;
    tick;
    chk("ready_after_rst", sig_ready, 1);
    // single packet, sink always ready
    sig_data = {tb, ta};
    sig_valid = 1'b1;
    outa_tready = 1'b1;
    tick;
    sig_valid = 1'b0;
    chk("lat_not_yet", outa_tvalid, 0);
    tick;
    chk("beat0_valid", outa_tvalid, 1);
    chk("beat0_data", outa_tdata, ta);
    chk("beat0_last", outa_tlast, 0);
    tick;
    chk("beat1_data", outa_tdata, tb);
    chk("beat1_last", outa_tlast, 1);
    tick;
    chk("single_done", outa_tvalid, 0);
    chk("single_count", pkt_count, 1);
    // backpressure on beat0
    outa_tready = 1'b0;
    sig_data = {{64{4'hD}}, {64{4'hC}}};
    sig_valid = 1'b1;
    tick;
    sig_valid = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("bp_tvalid", outa_tvalid, 1);
      chk("bp_tdata", outa_tdata, {64{4'hC}});
      chk("bp_tlast", outa_tlast, 0);
      tick;
    end
    outa_tready = 1'b1;
    tick;
    chk("bp_beat1", outa_tdata, {64{4'hD}});
    tick;
    chk("bp_done", outa_tvalid, 0);
    chk("bp_count", pkt_count, 2);
    // three packets offered into a stalled sink
    outa_tready = 1'b0;
    p1a = {32{8'h11}}; p1b = {32{8'h22}};
    p2a = {32{8'h33}}; p2b = {32{8'h44}};
    p3a = {32{8'h55}}; p3b = {32{8'h66}};
    seq = '{p1a, p1b, p2a, p2b, p3a, p3b};
    sig_valid = 1'b1;
    sig_data = {p1b, p1a};
    tick;
    sig_data = {p2b, p2a};
    tick;
    sig_data = {p3b, p3a};
    for (int i = 0; i < 3; i++) begin
      chk("full_ready_low", sig_ready, 0);
      tick;
    end
    outa_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("full_seq_valid", outa_tvalid, 1);
      chk("full_seq_data", outa_tdata, seq[i]);
      acc = sig_valid && sig_ready;
      tick;
      if (acc) sig_valid = 1'b0;
    end
    chk("full_accepted3", sig_valid, 0);
    chk("full_done", outa_tvalid, 0);
    chk("full_count", pkt_count, 5);
    // reset while beat1 is on the bus
    sig_data = {tb, ta};
    sig_valid = 1'b1;
    tick;
    sig_valid = 1'b0;
    tick;
    tick;
    outa_tready = 1'b0;
    chk("pre_rst_beat1", outa_tdata, tb);
    #2 rst = 1'b1;
    #1;
    chk("async_tvalid", outa_tvalid, 0);
    chk("async_tlast", outa_tlast, 0);
    chk("async_tdata", outa_tdata, 0);
    chk("async_ready", sig_ready, 0);
    chk("async_busy", busy, 0);
    chk("async_count", pkt_count, 0);
    tick;
    rst = 1'b0;
    outa_tready = 1'b1;
    repeat (6) begin
      tick;
      chk("no_replay", outa_tvalid, 0);
    end
    // packet counter wrap
    force dut.pkt_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    tick;
    release dut.pkt_count;
    chk("preload", pkt_count, 16'hFFFF);
    sig_data = {tb, ta};
    sig_valid = 1'b1;
    tick;
    sig_valid = 1'b0;
    repeat (3) tick;
    chk("wrap_count", pkt_count, 0);
    // byte-order pattern on beat0
    s0 = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
`ifdef SIG_BSWAP_EN
    s0x = 256'h201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504030201;
`else
    s0x = s0;
`endif
    sig_data = {tb, s0};
    sig_valid = 1'b1;
    tick;
    sig_valid = 1'b0;
    tick;
    chk("bswap_beat0", outa_tdata, s0x);
    repeat (3) tick;
    chk("final_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
